// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the RV32I pipeline.
// Issues in-order word fetches to instruction memory with at most two
// requests in flight. Returned words are held in a 2-entry FIFO whose head
// (instruction, PC and the decode fields) is presented to the decode stage.
// A flush redirects the fetch PC. Responses to requests that were already
// in flight at the time of the flush are counted and discarded.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode,
  output logic [2:0]  if_fun3,
  output logic        if_fun7
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Entry 0 is always the head; entry 1 is only meaningful when occ == 2.
  fetch_entry_t fifo_q [2];

  logic [31:0] pc_q;        // next fetch address
  logic [31:0] resp_pc_q;   // PC belonging to the next accepted response
  logic [1:0]  occ;         // FIFO occupancy, 0..2
  logic [1:0]  pend;        // requests in flight, 0..2
  logic [1:0]  drop;        // in-flight responses to discard after a flush

  logic        pop;
  logic        accept;
  logic        push;
  logic        wr_idx;
  logic [2:0]  credit_use;
  logic [31:0] redirect_pc;

  // Handshake decode: pop/push qualification and the issue credit check.
  // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
  always_comb begin
    pop         = if_valid & ~stall & ~flush;
    credit_use  = {1'b0, occ} + {1'b0, pend} - {2'b00, pop};
    imem_req    = ~rst & ~flush & (credit_use < 3'd2);
    accept      = imem_rvalid & (pend != 2'd0);
    push        = accept & (drop == 2'd0) & ~flush;
    // Slot that receives a pushed word once the pop (if any) has shifted the
    // FIFO: occ - pop, where a push never meets a full FIFO, so bit 0 suffices.
    wr_idx      = occ[0] ^ pop;
    redirect_pc = flush_pc & ~32'h0000_0003;
  end

  assign imem_addr = pc_q;
  assign if_valid  = (occ != 2'd0);
  assign if_instr  = if_valid ? fifo_q[0].instr : NOP_INSTR;
  assign if_pc     = fifo_q[0].pc;
  assign if_opcode = if_instr[6:0];
  assign if_fun3   = if_instr[14:12];
  assign if_fun7   = if_instr[30];

  // Fetch state: PC generation, credit/drop accounting and FIFO update.
  // NOTE: all state here uses non-blocking assignments, so a later write to the
  // same FIFO slot in this block overrides the shift, with every right-hand
  // side reading pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      occ       <= 2'd0;
      pend      <= 2'd0;
      drop      <= 2'd0;
      // NOTE: the FIFO payload is reset only because the head PC is visible on
      // if_pc during reset; the storage itself would not otherwise need it.
      fifo_q[0] <= '{pc: RESET_PC, instr: NOP_INSTR};
      fifo_q[1] <= '{pc: RESET_PC, instr: NOP_INSTR};
    end else if (flush) begin
      // Redirect: drop the buffer, and mark every response still in flight
      // (minus one returning this very cycle, which is discarded now) as stale.
      pc_q      <= redirect_pc;
      resp_pc_q <= redirect_pc;
      occ       <= 2'd0;
      pend      <= pend - {1'b0, accept};
      drop      <= pend - {1'b0, accept};
    end else begin
      if (imem_req) begin
        pc_q <= pc_q + 32'd4;
      end
      pend <= pend + {1'b0, imem_req} - {1'b0, accept};
      if (accept && (drop != 2'd0)) begin
        drop <= drop - 2'd1;
      end
      if (push) begin
        resp_pc_q <= resp_pc_q + 32'd4;
      end
      if (pop) begin
        fifo_q[0] <= fifo_q[1];
      end
      if (push) begin
        fifo_q[wr_idx] <= '{pc: resp_pc_q, instr: imem_rdata};
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// A behavioural memory with selectable latency answers every observed request
// with an address-tagged word. Each issued request pushes its expected PC onto
// a scoreboard, and each instruction consumed by decode is popped and compared.
// Two instances are used so that both the default reset PC and a wrapping
// reset PC are exercised. The unselected instance is held in reset.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] LO_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HI_RESET_PC = 32'hFFFF_FFF8;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mem_req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, stall, flush;
  logic [31:0] flush_pc;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        rst0, rst1;

  logic        imem_req_0, imem_req_1, if_valid_0, if_valid_1, if_fun7_0, if_fun7_1;
  logic [31:0] imem_addr_0, imem_addr_1, if_instr_0, if_instr_1, if_pc_0, if_pc_1;
  logic [6:0]  if_opcode_0, if_opcode_1;
  logic [2:0]  if_fun3_0, if_fun3_1;

  logic        imem_req, if_valid, if_fun7;
  logic [31:0] imem_addr, if_instr, if_pc;
  logic [6:0]  if_opcode;
  logic [2:0]  if_fun3;

  assign rst0 = rst | sel;
  assign rst1 = rst | ~sel;

  assign imem_req  = sel ? imem_req_1  : imem_req_0;
  assign imem_addr = sel ? imem_addr_1 : imem_addr_0;
  assign if_valid  = sel ? if_valid_1  : if_valid_0;
  assign if_instr  = sel ? if_instr_1  : if_instr_0;
  assign if_pc     = sel ? if_pc_1     : if_pc_0;
  assign if_opcode = sel ? if_opcode_1 : if_opcode_0;
  assign if_fun3   = sel ? if_fun3_1   : if_fun3_0;
  assign if_fun7   = sel ? if_fun7_1   : if_fun7_0;

  instr_fetch_unit u_dut_lo (
    .clk         (clk),
    .rst         (rst0),
    .imem_req    (imem_req_0),
    .imem_addr   (imem_addr_0),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .if_valid    (if_valid_0),
    .if_instr    (if_instr_0),
    .if_pc       (if_pc_0),
    .if_opcode   (if_opcode_0),
    .if_fun3     (if_fun3_0),
    .if_fun7     (if_fun7_0)
  );

  instr_fetch_unit #(.RESET_PC(HI_RESET_PC)) u_dut_hi (
    .clk         (clk),
    .rst         (rst1),
    .imem_req    (imem_req_1),
    .imem_addr   (imem_addr_1),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .if_valid    (if_valid_1),
    .if_instr    (if_instr_1),
    .if_pc       (if_pc_1),
    .if_opcode   (if_opcode_1),
    .if_fun3     (if_fun3_1),
    .if_fun7     (if_fun7_1)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          mem_lat = 1;
  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch_pc;

  // Address-tagged instruction word; spreads the address into every decode field.
  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return (addr * 32'h0019_660D) ^ 32'h4000_5033;
  endfunction

  // One clock cycle: drive memory response and controls at the falling edge,
  // then check consumed instructions and record issued requests.
  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] fpc);
    logic [31:0] e_pc;
    logic [31:0] e_w;
    @(negedge clk);
    if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    rst      = r;
    stall    = s;
    flush    = f;
    flush_pc = fpc;
    #1;
    if (!r && !s && !f && if_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra cyc=%0d got pc=%h instr=%h, expected no instruction", cyc, if_pc, if_instr);
      end else begin
        e_pc = exp_q.pop_front();
        e_w  = word_of(e_pc);
        if (if_pc !== e_pc || if_instr !== e_w || if_opcode !== e_w[6:0] ||
            if_fun3 !== e_w[14:12] || if_fun7 !== e_w[30]) begin
          errors++;
          $display("FAIL sb_head cyc=%0d got pc=%h instr=%h op=%h f3=%h f7=%b exp pc=%h instr=%h",
                   cyc, if_pc, if_instr, if_opcode, if_fun3, if_fun7, e_pc, e_w);
        end
      end
    end
    if (!r && imem_req) begin
      checks++;
      if (imem_addr !== exp_fetch_pc) begin
        errors++;
        $display("FAIL sb_addr cyc=%0d got %h exp %h", cyc, imem_addr, exp_fetch_pc);
      end
      exp_q.push_back(exp_fetch_pc);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      mem_q.push_back('{due: cyc + mem_lat, addr: imem_addr});
    end
    if (r) begin
      exp_q.delete();
      exp_fetch_pc = sel ? HI_RESET_PC : LO_RESET_PC;
    end else if (f) begin
      exp_q.delete();
      exp_fetch_pc = fpc & ~32'h3;
    end
    cyc++;
  endtask

  task automatic drain();
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i[0], i[0], 32'h40);
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_instr !== NOP || if_pc !== LO_RESET_PC) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got req=%b valid=%b instr=%h pc=%h exp 0 0 %h %h",
                 cyc, imem_req, if_valid, if_instr, if_pc, NOP, LO_RESET_PC);
      end
    end
  endtask

  task automatic test_stream();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== LO_RESET_PC) begin
      errors++;
      $display("FAIL first_req got req=%b addr=%h exp 1 %h", imem_req, imem_addr, LO_RESET_PC);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL cycle1_valid got %b exp 0", if_valid);
    end
    for (int k = 2; k < 18; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 2))) begin
        errors++;
        $display("FAIL stream_pc k=%0d got valid=%b pc=%h exp 1 %h", k, if_valid, if_pc, 32'(4 * (k - 2)));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        held_pc    = if_pc;
        held_instr = if_instr;
      end
      checks++;
      if (if_valid !== 1'b1 || if_pc !== held_pc || if_instr !== held_instr) begin
        errors++;
        $display("FAIL stall_hold i=%0d got valid=%b pc=%h instr=%h exp 1 %h %h",
                 i, if_valid, if_pc, if_instr, held_pc, held_instr);
      end
      if (i >= 1) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL stall_req i=%0d got %b exp 0", i, imem_req);
        end
      end
    end
    checks++;
    if (mem_q.size() != 0) begin
      errors++;
      $display("FAIL stall_pending got %0d outstanding exp 0", mem_q.size());
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_flush_stall();
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL fs_flush_req got %b exp 0", imem_req);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL fs_t1 got valid=%b req=%b addr=%h exp 0 1 00000200", if_valid, imem_req, imem_addr);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL fs_t2 got valid=%b exp 0", if_valid);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      errors++;
      $display("FAIL fs_t3 got valid=%b pc=%h exp 1 00000200", if_valid, if_pc);
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_flush_outstanding();
    logic seen_req;
    logic seen_valid;
    seen_req   = 1'b0;
    seen_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (mem_q.size() != 2) begin
      errors++;
      $display("FAIL fo_outstanding got %0d exp 2", mem_q.size());
    end
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL fo_flush_req got %b exp 0", imem_req);
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (!seen_req && imem_req) begin
        seen_req = 1'b1;
        checks++;
        if (imem_addr !== 32'h100) begin
          errors++;
          $display("FAIL fo_redirect_addr got %h exp 00000100", imem_addr);
        end
      end
      if (!seen_valid && if_valid) begin
        seen_valid = 1'b1;
        checks++;
        if (if_pc !== 32'h100) begin
          errors++;
          $display("FAIL fo_first_pc got %h exp 00000100", if_pc);
        end
      end
    end
    checks++;
    if (!seen_req || !seen_valid) begin
      errors++;
      $display("FAIL fo_timeout got req_seen=%b valid_seen=%b exp 1 1", seen_req, seen_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic found;
    logic seen_valid;
    found      = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (if_valid && imem_req && mem_q.size() == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rm_setup got no cycle with 1 buffered and 2 outstanding");
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (if_valid !== 1'b0 || if_instr !== NOP || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL rm_in_reset i=%0d got valid=%b instr=%h req=%b exp 0 %h 0",
                 i, if_valid, if_instr, imem_req, NOP);
      end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== LO_RESET_PC) begin
      errors++;
      $display("FAIL rm_restart got req=%b addr=%h exp 1 %h", imem_req, imem_addr, LO_RESET_PC);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_late_ignored got valid=%b pc=%h exp 0", if_valid, if_pc);
    end
    for (int i = 0; i < 10 && !seen_valid; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (if_valid) begin
        seen_valid = 1'b1;
        checks++;
        if (if_pc !== LO_RESET_PC) begin
          errors++;
          $display("FAIL rm_first_pc got %h exp %h", if_pc, LO_RESET_PC);
        end
      end
    end
    checks++;
    if (!seen_valid) begin
      errors++;
      $display("FAIL rm_timeout got no valid instruction after restart");
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e_pc;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== HI_RESET_PC) begin
      errors++;
      $display("FAIL wrap_first_req got req=%b addr=%h exp 1 %h", imem_req, imem_addr, HI_RESET_PC);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      e_pc = HI_RESET_PC + 32'(4 * k);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== e_pc) begin
        errors++;
        $display("FAIL wrap_pc k=%0d got valid=%b pc=%h exp 1 %h", k, if_valid, if_pc, e_pc);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    sel          = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    flush_pc     = 32'h0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    exp_fetch_pc = LO_RESET_PC;

    test_reset();
    test_stream();
    test_stall();
    test_flush_stall();
    drain();
    mem_lat = 3;
    test_flush_outstanding();
    test_reset_midstream();
    drain();
    mem_lat = 1;
    sel = 1'b1;
    drain();
    test_wrap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
